// File: rtl/painterengine_gpu_dma_pkg.sv
// -----------------------------------------------------------------------------
// painterengine_gpu_dma_pkg
// Shared definitions for the GPU DMA engines (reader now, writer later):
// FSM state codes, fixed AXI field encodings and 4 KB page helpers.
// -----------------------------------------------------------------------------
package painterengine_gpu_dma_pkg;

    // State codes are exposed on the debug readback port, so the encoding
    // is part of the interface and must not change.
    typedef enum logic [7:0] {
        ST_IDLE  = 8'd0,
        ST_ADDR  = 8'd1,
        ST_DATA  = 8'd2,
        ST_DONE  = 8'd3,
        ST_ERROR = 8'd4,
        ST_DRAIN = 8'd5
    } dma_state_t;

    localparam logic [2:0]  AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam logic [12:0] PAGE_BYTES     = 13'h1000;

    // Number of whole 32-bit words left before the next 4 KB boundary.
    // For a word-aligned offset the result lies in 1..1024.
    function automatic logic [10:0] page_room_words(input logic [11:0] page_off);
        logic [12:0] room_bytes;
        room_bytes = PAGE_BYTES - {1'b0, page_off};
        return room_bytes[12:2];
    endfunction

endpackage

// File: rtl/painterengine_gpu_dma_reader_if.sv
// -----------------------------------------------------------------------------
// painterengine_gpu_dma_reader_if
// AXI4 read address/data channels plus the task-FIFO push port of the DMA
// reader. master = the DMA reader, slave = memory interconnect / FIFO side.
// -----------------------------------------------------------------------------
interface painterengine_gpu_dma_reader_if;
    // AXI4 read address channel
    logic [31:0] o_wire_axi_araddr;
    logic [7:0]  o_wire_axi_arlen;
    logic [2:0]  o_wire_axi_arsize;
    logic [1:0]  o_wire_axi_arburst;
    logic        o_wire_axi_arvalid;
    logic        i_wire_axi_arready;
    // AXI4 read data channel
    logic [31:0] i_wire_axi_rdata;
    logic [1:0]  i_wire_axi_rresp;
    logic        i_wire_axi_rlast;
    logic        i_wire_axi_rvalid;
    logic        o_wire_axi_rready;
    // Task FIFO push port
    logic [31:0] o_wire_fifo_data;
    logic        o_wire_fifo_write;
    logic        i_wire_fifo_full;

    modport master (
        output o_wire_axi_araddr, o_wire_axi_arlen, o_wire_axi_arsize,
               o_wire_axi_arburst, o_wire_axi_arvalid, o_wire_axi_rready,
               o_wire_fifo_data, o_wire_fifo_write,
        input  i_wire_axi_arready, i_wire_axi_rdata, i_wire_axi_rresp,
               i_wire_axi_rlast, i_wire_axi_rvalid, i_wire_fifo_full
    );

    modport slave (
        input  o_wire_axi_araddr, o_wire_axi_arlen, o_wire_axi_arsize,
               o_wire_axi_arburst, o_wire_axi_arvalid, o_wire_axi_rready,
               o_wire_fifo_data, o_wire_fifo_write,
        output i_wire_axi_arready, i_wire_axi_rdata, i_wire_axi_rresp,
               i_wire_axi_rlast, i_wire_axi_rvalid, i_wire_fifo_full
    );
endinterface

// File: rtl/painterengine_gpu_dma_burst_calc.sv
// -----------------------------------------------------------------------------
// painterengine_gpu_dma_burst_calc
// Combinational burst sizing: beats = min(remaining, MAX_BURST, words left in
// the current 4 KB page), so no burst crosses a page boundary.
//   page_off_i   : byte offset of the burst start within its 4 KB page
//   remaining_i  : words still to transfer (must be non-zero when used)
//   beats_o      : beats in the burst (1..MAX_BURST)
//   arlen_o      : AXI arlen encoding (beats-1)
// -----------------------------------------------------------------------------
module painterengine_gpu_dma_burst_calc
    import painterengine_gpu_dma_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic [11:0] page_off_i,
    input  logic [31:0] remaining_i,
    output logic [8:0]  beats_o,
    output logic [7:0]  arlen_o
);
    localparam logic [31:0] MAX_BURST_W = 32'(MAX_BURST);

    logic [31:0] room_d;
    logic [31:0] lim_d;

    always_comb begin
        room_d = {21'd0, page_room_words(page_off_i)};
        lim_d  = remaining_i;
        if (MAX_BURST_W < lim_d) lim_d = MAX_BURST_W;
        if (room_d < lim_d)      lim_d = room_d;
        beats_o = lim_d[8:0];
        arlen_o = 8'(lim_d - 32'd1);
    end
endmodule

// File: rtl/painterengine_gpu_dma_reader.sv
// -----------------------------------------------------------------------------
// painterengine_gpu_dma_reader
// DMA read engine for the GPU task controllers. Fetches i_wire_length words
// from i_wire_address over AXI4 INCR bursts (one AR outstanding) and pushes
// them in order into the task FIFO.
// Ports:
//   i_wire_clock / i_wire_reset : clock, synchronous active-high reset
//   i_wire_run                  : 0 = idle/clear, rising = start
//   i_wire_address/_length      : byte address / word count, sampled at start
//   o_wire_done / o_wire_error  : sticky status until run is dropped
//   o_wire_state                : {24'd0, state code} debug readback
//   bus                         : AXI read channels + FIFO push (master)
// -----------------------------------------------------------------------------
module painterengine_gpu_dma_reader
    import painterengine_gpu_dma_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic        i_wire_clock,
    input  logic        i_wire_reset,
    input  logic        i_wire_run,
    input  logic [31:0] i_wire_address,
    input  logic [31:0] i_wire_length,
    output logic        o_wire_done,
    output logic        o_wire_error,
    output logic [31:0] o_wire_state,
    painterengine_gpu_dma_reader_if.master bus
);
    dma_state_t  state_q;
    logic [31:0] addr_q;
    logic [31:0] remaining_q;
    logic [8:0]  beat_cnt_q;
    logic [31:0] araddr_q;
    logic [7:0]  arlen_q;
    logic        arvalid_q;
    logic        done_q;
    logic        error_q;
    logic        err_pending_q;

    logic [31:0] addr_next_d;
    logic [31:0] remaining_next_d;
    logic [11:0] calc_page_off_d;
    logic [31:0] calc_rem_d;
    logic [8:0]  calc_beats;
    logic [7:0]  calc_arlen;
    logic        rready_d;
    logic        beat_acc_d;
    logic        last_beat_d;
    logic        bad_beat_d;

    assign addr_next_d      = addr_q + 32'd4;
    assign remaining_next_d = remaining_q - 32'd1;

    // The next burst is sized from the values the counters will hold after
    // this edge: the start inputs in IDLE, the post-beat values in DATA.
    assign calc_page_off_d = (state_q == ST_IDLE) ? i_wire_address[11:0] : addr_next_d[11:0];
    assign calc_rem_d      = (state_q == ST_IDLE) ? i_wire_length : remaining_next_d;

    painterengine_gpu_dma_burst_calc #(
        .MAX_BURST (MAX_BURST)
    ) u_burst_calc (
        .page_off_i  (calc_page_off_d),
        .remaining_i (calc_rem_d),
        .beats_o     (calc_beats),
        .arlen_o     (calc_arlen)
    );

    assign rready_d    = ((state_q == ST_DATA) && !bus.i_wire_fifo_full) || (state_q == ST_DRAIN);
    assign beat_acc_d  = bus.i_wire_axi_rvalid && rready_d;
    assign last_beat_d = (beat_cnt_q == 9'd1);
    // The local beat counter is authoritative; an rlast that disagrees with
    // it is treated as a bus error just like a non-OKAY response.
    assign bad_beat_d  = (bus.i_wire_axi_rresp != AXI_RESP_OKAY) ||
                         (bus.i_wire_axi_rlast != last_beat_d);

    // A beat accepted in the cycle run is seen low is already part of the
    // abort, so it is not pushed.
    assign bus.o_wire_fifo_write  = (state_q == ST_DATA) && beat_acc_d && !bad_beat_d && i_wire_run;
    assign bus.o_wire_fifo_data   = bus.o_wire_fifo_write ? bus.i_wire_axi_rdata : 32'd0;
    assign bus.o_wire_axi_rready  = rready_d;
    assign bus.o_wire_axi_araddr  = araddr_q;
    assign bus.o_wire_axi_arlen   = arlen_q;
    assign bus.o_wire_axi_arsize  = AXI_SIZE_4B;
    assign bus.o_wire_axi_arburst = AXI_BURST_INCR;
    assign bus.o_wire_axi_arvalid = arvalid_q;

    assign o_wire_done  = done_q;
    assign o_wire_error = error_q;
    assign o_wire_state = {24'd0, state_q};

    always_ff @(posedge i_wire_clock) begin
        if (i_wire_reset) begin
            state_q       <= ST_IDLE;
            addr_q        <= 32'd0;
            remaining_q   <= 32'd0;
            beat_cnt_q    <= 9'd0;
            araddr_q      <= 32'd0;
            arlen_q       <= 8'd0;
            arvalid_q     <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            err_pending_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_wire_run) begin
                        addr_q      <= i_wire_address;
                        remaining_q <= i_wire_length;
                        if (i_wire_address[1:0] != 2'b00) begin
                            state_q <= ST_ERROR;
                            error_q <= 1'b1;
                        end else if (i_wire_length == 32'd0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= ST_ADDR;
                            arvalid_q  <= 1'b1;
                            araddr_q   <= i_wire_address;
                            arlen_q    <= calc_arlen;
                            beat_cnt_q <= calc_beats;
                        end
                    end
                end
                ST_ADDR: begin
                    // AR must complete even when aborted; its data is drained.
                    if (bus.i_wire_axi_arready) begin
                        arvalid_q <= 1'b0;
                        state_q   <= i_wire_run ? ST_DATA : ST_DRAIN;
                    end
                end
                ST_DATA: begin
                    if (beat_acc_d) begin
                        beat_cnt_q  <= beat_cnt_q - 9'd1;
                        addr_q      <= addr_next_d;
                        remaining_q <= remaining_next_d;
                        if (last_beat_d) begin
                            if (bad_beat_d) begin
                                state_q <= ST_ERROR;
                                error_q <= 1'b1;
                            end else if (!i_wire_run) begin
                                state_q <= ST_IDLE;
                            end else if (remaining_next_d == 32'd0) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q    <= ST_ADDR;
                                arvalid_q  <= 1'b1;
                                araddr_q   <= addr_next_d;
                                arlen_q    <= calc_arlen;
                                beat_cnt_q <= calc_beats;
                            end
                        end else if (bad_beat_d) begin
                            err_pending_q <= 1'b1;
                            state_q       <= ST_DRAIN;
                        end else if (!i_wire_run) begin
                            state_q <= ST_DRAIN;
                        end
                    end else if (!i_wire_run) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (beat_acc_d) begin
                        beat_cnt_q <= beat_cnt_q - 9'd1;
                        if (last_beat_d) begin
                            err_pending_q <= 1'b0;
                            if (err_pending_q) begin
                                state_q <= ST_ERROR;
                                error_q <= 1'b1;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (!i_wire_run) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b0;
                    end
                end
                ST_ERROR: begin
                    if (!i_wire_run) begin
                        state_q <= ST_IDLE;
                        error_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_painterengine_gpu_dma_reader.sv
module tb_painterengine_gpu_dma_reader;
    logic        clk = 1'b0;
    logic        srst;
    logic        run;
    logic [31:0] address;
    logic [31:0] length;
    logic        done;
    logic        error;
    logic [31:0] state;

    always #5 clk = ~clk;

    painterengine_gpu_dma_reader_if bus();

    painterengine_gpu_dma_reader #(.MAX_BURST(16)) dut (
        .i_wire_clock   (clk),
        .i_wire_reset   (srst),
        .i_wire_run     (run),
        .i_wire_address (address),
        .i_wire_length  (length),
        .o_wire_done    (done),
        .o_wire_error   (error),
        .o_wire_state   (state),
        .bus            (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Scoreboards
    logic [31:0] exp_word_q[$];
    logic [39:0] exp_ar_q[$];   // {arlen, araddr}
    int ar_count = 0, wr_count = 0, stall_cnt = 0, extra_ar = 0, extra_wr = 0;
    bit ignore_mon = 0;

    // Memory slave control
    int err_beat = -1;
    int s_beat_glob = 0;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_ar(input logic [31:0] a, input logic [7:0] len);
        exp_ar_q.push_back({len, a});
    endtask

    task automatic push_words(input logic [31:0] a, input int n);
        for (int i = 0; i < n; i++) exp_word_q.push_back(mem_word(a + 32'(4 * i)));
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] len);
        address = a;
        length  = len;
        run     = 1'b1;
    endtask

    task automatic wait_end(input string tag, input int budget);
        int n = 0;
        while (!(done || error) && n < budget) begin
            tick();
            n++;
        end
        if (!(done || error)) check_val({tag, "_timeout"}, {31'd0, done | error}, 32'd1);
    endtask

    task automatic wait_wr(input string tag, input int target, input int budget);
        int n = 0;
        while (wr_count < target && n < budget) begin
            tick();
            n++;
        end
        if (wr_count < target) check_val({tag, "_wr_timeout"}, 32'(wr_count), 32'(target));
    endtask

    task automatic end_run(input string tag);
        run = 1'b0;
        tick();
        check_val({tag, "_idle_state"}, state, 32'd0);
        check_val({tag, "_idle_flags"}, {30'd0, done, error}, 32'd0);
    endtask

    // AXI memory slave: one burst at a time, data every cycle
    initial begin : slave
        logic ar_hs, r_hs, rst_s;
        logic [31:0] ar_addr_s, s_addr;
        int ar_len_s, s_left;
        logic s_busy;
        s_busy = 1'b0; s_left = 0; s_addr = 32'd0;
        bus.i_wire_axi_arready = 1'b0;
        bus.i_wire_axi_rvalid  = 1'b0;
        bus.i_wire_axi_rdata   = 32'd0;
        bus.i_wire_axi_rresp   = 2'b00;
        bus.i_wire_axi_rlast   = 1'b0;
        forever begin
            @(negedge clk);
            rst_s     = srst;
            ar_hs     = bus.o_wire_axi_arvalid && bus.i_wire_axi_arready;
            r_hs      = bus.i_wire_axi_rvalid && bus.o_wire_axi_rready;
            ar_addr_s = bus.o_wire_axi_araddr;
            ar_len_s  = int'(bus.o_wire_axi_arlen);
            @(posedge clk);
            #1;
            if (rst_s) begin
                s_busy = 1'b0;
                s_left = 0;
            end else begin
                if (r_hs && s_busy) begin
                    s_left--;
                    s_addr += 32'd4;
                    s_beat_glob++;
                    if (s_left == 0) s_busy = 1'b0;
                end
                if (ar_hs) begin
                    s_busy = 1'b1;
                    s_addr = ar_addr_s;
                    s_left = ar_len_s + 1;
                end
            end
            bus.i_wire_axi_arready = !s_busy;
            bus.i_wire_axi_rvalid  = s_busy;
            bus.i_wire_axi_rdata   = s_busy ? mem_word(s_addr) : 32'd0;
            bus.i_wire_axi_rlast   = s_busy && (s_left == 1);
            bus.i_wire_axi_rresp   = (s_busy && s_beat_glob == err_beat) ? 2'b10 : 2'b00;
        end
    end

    // Output monitor: AR and FIFO scoreboards, stall counting
    initial begin : monitor
        logic [39:0] e;
        logic [31:0] w;
        forever begin
            @(negedge clk);
            if (!srst) begin
                if (bus.o_wire_axi_arvalid && bus.i_wire_axi_arready) begin
                    ar_count++;
                    if (!ignore_mon) begin
                        if (exp_ar_q.size() > 0) begin
                            e = exp_ar_q.pop_front();
                            check_val("ar_addr", bus.o_wire_axi_araddr, e[31:0]);
                            check_val("ar_len", {24'd0, bus.o_wire_axi_arlen}, {24'd0, e[39:32]});
                        end else begin
                            extra_ar++;
                        end
                    end
                end
                if (bus.o_wire_fifo_write) begin
                    wr_count++;
                    if (!ignore_mon) begin
                        if (exp_word_q.size() > 0) begin
                            w = exp_word_q.pop_front();
                            check_val("fifo_word", bus.o_wire_fifo_data, w);
                        end else begin
                            extra_wr++;
                        end
                    end
                end
                if (state == 32'd2 && !bus.o_wire_axi_rready) stall_cnt++;
            end
        end
    end

    initial begin : main
        int w0, a0, s0, n;
        srst = 1'b1; run = 1'b0; address = 32'd0; length = 32'd0;
        bus.i_wire_fifo_full = 1'b0;
        tick(3);
        check_val("rst_state", state, 32'd0);
        check_val("rst_flags", {29'd0, done, error, bus.o_wire_axi_arvalid}, 32'd0);
        check_val("rst_rready_wr", {30'd0, bus.o_wire_axi_rready, bus.o_wire_fifo_write}, 32'd0);
        check_val("rst_araddr", bus.o_wire_axi_araddr, 32'd0);
        check_val("rst_arlen", {24'd0, bus.o_wire_axi_arlen}, 32'd0);
        check_val("arsize_arburst", {27'd0, bus.o_wire_axi_arsize, bus.o_wire_axi_arburst}, 32'h09);
        srst = 1'b0;
        tick(2);

        // 1: two full bursts
        s_beat_glob = 0; err_beat = -1;
        push_ar(32'h1000, 8'd15); push_ar(32'h1040, 8'd15); push_words(32'h1000, 32);
        w0 = wr_count;
        start(32'h1000, 32'd32);
        wait_end("t1", 500);
        check_val("t1_done_err", {30'd0, done, error}, 32'h2);
        check_val("t1_writes", 32'(wr_count - w0), 32'd32);
        check_val("t1_words_left", 32'(exp_word_q.size()), 32'd0);
        check_val("t1_ar_left", 32'(exp_ar_q.size()), 32'd0);
        check_val("t1_state", state, 32'd3);
        end_run("t1");

        // 2: 4 KB boundary split
        s_beat_glob = 0;
        push_ar(32'h1FF8, 8'd1); push_ar(32'h2000, 8'd1); push_words(32'h1FF8, 4);
        w0 = wr_count;
        start(32'h1FF8, 32'd4);
        wait_end("t2", 200);
        check_val("t2_done_err", {30'd0, done, error}, 32'h2);
        check_val("t2_writes", 32'(wr_count - w0), 32'd4);
        check_val("t2_ar_left", 32'(exp_ar_q.size()), 32'd0);
        end_run("t2");

        // 3: error response on beat 3
        s_beat_glob = 0; err_beat = 3;
        push_ar(32'h2100, 8'd7); push_words(32'h2100, 3);
        w0 = wr_count; a0 = ar_count;
        start(32'h2100, 32'd8);
        wait_end("t3", 200);
        tick(3);
        check_val("t3_done_err", {30'd0, done, error}, 32'h1);
        check_val("t3_writes", 32'(wr_count - w0), 32'd3);
        check_val("t3_ar_count", 32'(ar_count - a0), 32'd1);
        check_val("t3_words_left", 32'(exp_word_q.size()), 32'd0);
        err_beat = -1;
        end_run("t3");

        // 4: FIFO full for 5 cycles mid-burst
        s_beat_glob = 0;
        push_ar(32'h3000, 8'd15); push_words(32'h3000, 16);
        w0 = wr_count; s0 = stall_cnt;
        start(32'h3000, 32'd16);
        wait_wr("t4", w0 + 6, 100);
        bus.i_wire_fifo_full = 1'b1;
        tick(5);
        bus.i_wire_fifo_full = 1'b0;
        wait_end("t4", 200);
        check_val("t4_done_err", {30'd0, done, error}, 32'h2);
        check_val("t4_stalls", 32'(stall_cnt - s0), 32'd5);
        check_val("t4_writes", 32'(wr_count - w0), 32'd16);
        check_val("t4_words_left", 32'(exp_word_q.size()), 32'd0);
        end_run("t4");

        // 5: run dropped after 4 beats, then restart
        s_beat_glob = 0;
        push_ar(32'h6000, 8'd15); push_words(32'h6000, 4);
        w0 = wr_count;
        start(32'h6000, 32'd16);
        wait_wr("t5", w0 + 4, 100);
        run = 1'b0;
        tick();
        check_val("t5_drain_state", state, 32'd5);
        n = 0;
        while (state != 32'd0 && n < 100) begin tick(); n++; end
        check_val("t5_back_idle", state, 32'd0);
        check_val("t5_flags", {30'd0, done, error}, 32'd0);
        check_val("t5_writes", 32'(wr_count - w0), 32'd4);
        tick(2);
        s_beat_glob = 0;
        push_ar(32'h7000, 8'd3); push_words(32'h7000, 4);
        w0 = wr_count;
        start(32'h7000, 32'd4);
        wait_end("t5b", 200);
        check_val("t5b_done_err", {30'd0, done, error}, 32'h2);
        check_val("t5b_writes", 32'(wr_count - w0), 32'd4);
        check_val("t5b_words_left", 32'(exp_word_q.size()), 32'd0);
        end_run("t5b");

        // 6: misaligned start, zero length, reset mid-burst
        a0 = ar_count;
        start(32'h1002, 32'd4);
        tick();
        check_val("t6_misaligned_err", {30'd0, done, error}, 32'h1);
        check_val("t6_misaligned_state", state, 32'd4);
        end_run("t6a");
        start(32'h4000, 32'd0);
        tick();
        check_val("t6_len0_done", {30'd0, done, error}, 32'h2);
        end_run("t6b");
        check_val("t6_no_ar", 32'(ar_count - a0), 32'd0);

        ignore_mon = 1;
        w0 = wr_count;
        start(32'h5000, 32'd32);
        wait_wr("t6c", w0 + 5, 100);
        srst = 1'b1;
        tick();
        check_val("t6_rst_state", state, 32'd0);
        check_val("t6_rst_flags", {29'd0, done, error, bus.o_wire_axi_arvalid}, 32'd0);
        check_val("t6_rst_rready_wr", {30'd0, bus.o_wire_axi_rready, bus.o_wire_fifo_write}, 32'd0);
        check_val("t6_rst_fifo_data", bus.o_wire_fifo_data, 32'd0);
        check_val("t6_rst_araddr", bus.o_wire_axi_araddr, 32'd0);
        check_val("t6_rst_arlen", {24'd0, bus.o_wire_axi_arlen}, 32'd0);
        run = 1'b0;
        tick(2);
        srst = 1'b0;
        tick(2);
        ignore_mon = 0;
        exp_word_q.delete();
        exp_ar_q.delete();

        check_val("extra_ar_total", 32'(extra_ar), 32'd0);
        check_val("extra_wr_total", 32'(extra_wr), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/painterengine_gpu_dma_reader.md
Name: painterengine_gpu_dma_reader

Overview:
- DMA read engine that answers the GPU task controllers: it fetches i_wire_length 32-bit words from i_wire_address over an AXI4 read channel and pushes them in order into the task FIFO.
- It reports completion or failure back to the controller through level done/error flags.
- It sits between the memcpy/colorconvert controllers and the memory interconnect. It is the responder for the controller's dma_reader run/address/length/done/error interface.

Parameters:
- MAX_BURST, 16, maximum AXI INCR beats per burst (1..256).

Ports:
- i_wire_clock  in  1  system clock
- i_wire_reset  in  1  synchronous active-high reset
- i_wire_run  in  1  driven by the controller's dma_reader_resetn; 0 = hold idle/clear, 0->1 = start
- i_wire_address  in  32  source byte address, sampled at start
- i_wire_length  in  32  transfer length in 32-bit words, sampled at start
- o_wire_done  out  1  transfer complete, sticky until run=0
- o_wire_error  out  1  transfer failed, sticky until run=0
- o_wire_axi_araddr  out  32  burst start address
- o_wire_axi_arlen  out  8  beats-1
- o_wire_axi_arsize  out  3  constant 3'b010
- o_wire_axi_arburst  out  2  constant 2'b01 (INCR)
- o_wire_axi_arvalid  out  1
- i_wire_axi_arready  in  1
- i_wire_axi_rdata  in  32
- i_wire_axi_rresp  in  2
- i_wire_axi_rlast  in  1
- i_wire_axi_rvalid  in  1
- o_wire_axi_rready  out  1
- o_wire_fifo_data  out  32  word to FIFO
- o_wire_fifo_write  out  1  FIFO push strobe
- i_wire_fifo_full  in  1
- o_wire_state  out  32  {24'd0, state code} for debug readback

Behaviour:
- Reset: state=IDLE; done, error, arvalid, rready and fifo_write all 0; araddr=0; arlen=0; internal address/remaining counters=0. i_wire_reset has priority over every state, including mid-burst.
- States and codes: IDLE=0, ADDR=1, DATA=2, DONE=3, ERROR=4, DRAIN=5.
- IDLE: when run=1, latch address and length.
  - address[1:0]!=0 -> ERROR.
  - length=0 -> DONE.
  - else -> ADDR.
  - Done is asserted 1 cycle after run is first sampled high.
- ADDR: drive arvalid=1 with:
  - araddr = current address.
  - arlen = beats-1, where beats = min(remaining, MAX_BURST, (4096-address[11:0])>>2). Bursts never cross a 4 KB boundary.
  - arvalid and all AR fields stay stable until arready. On handshake -> DATA, with beat counter = beats.
- DATA: rready = !i_wire_fifo_full. On rvalid&&rready:
  - fifo_write=1 and fifo_data=rdata, combinationally, in the same cycle.
  - remaining decrements by 1; address advances by 4.
- End of burst: when the beat counter reaches 0 (the cycle rlast is accepted):
  - remaining=0 -> DONE.
  - else -> ADDR. The next arvalid is asserted in the following cycle.
- rlast mismatch: rlast on a beat other than the counted last beat -> ERROR handling via DRAIN. The counter governs burst end.
- rresp!=0 on any beat:
  - That beat is not written to the FIFO; error_pending is set.
  - Remaining beats of the burst are accepted with rready=1 and discarded.
  - Then -> ERROR. No new AR is issued.
- DONE: done=1 held. ERROR: error=1 held. Both return to IDLE, cleared, the cycle after run=0 is sampled.
- run=0 mid-transfer:
  - In ADDR before the handshake: arvalid is held until arready, then the burst is drained.
  - In DATA: go to DRAIN.
- DRAIN: rready=1, fifo_write=0, until the outstanding beat count reaches 0, then IDLE with done=error=0. run must stay low for a restart; a run rise during DRAIN is ignored until IDLE.
- Only one AR is outstanding at a time.
- Throughput: 1 word/cycle when the FIFO is not full. Per burst overhead: 1 AR cycle plus 1 turnaround cycle.
- Arithmetic: remaining is 32 bits. Address wraps modulo 2^32; no error is raised on wrap.

Decomposition:
- Package painterengine_gpu_dma_pkg: state codes, AXI_SIZE_4B, AXI_BURST_INCR, AXI_RESP_OKAY, 4 KB page constant. Shared with the future dma_writer.
- Sub-module painterengine_gpu_dma_burst_calc: combinational beats/arlen computation from address, remaining and MAX_BURST.

Test Plan:
1. addr=0x1000, len=32, MAX_BURST=16, memory ready every cycle -> two bursts at 0x1000 and 0x1040, each arlen=15; 32 FIFO writes in order; done=1, error=0.
2. addr=0x1FF8, len=4 -> burst1 araddr=0x1FF8 arlen=1, burst2 araddr=0x2000 arlen=1; done=1.
3. len=8, rresp=2'b10 on beat 3 -> beats 0-2 written (3 FIFO writes), beats 3-7 accepted but not written, error=1, done=0, no further AR.
4. len=16, i_wire_fifo_full high for 5 cycles mid-burst -> rready=0 for exactly those cycles, no lost or duplicated words, done=1.
5. run dropped after 4 of 16 beats -> state=DRAIN, remaining 12 beats accepted with no FIFO writes, then IDLE with done=0; a new run with len=4 completes correctly.
6. Edge starts: addr=0x1002 -> error=1 one cycle after start, no AR issued. len=0 -> done=1 one cycle after start, no AR issued. i_wire_reset mid-burst -> all outputs 0 next cycle.
